// File: rtl/cache_trace_driver.sv
// Purpose: exercise the data cache in three phases (read-compare, write, read-back verify) against a trace ROM.
// Latency: one request in flight at a time; each access costs one or more request cycles plus the cache response delay.
// Backpressure: req_* are held stable while req_ready=0; a missing response fails the run after TIMEOUT wait cycles.
module cache_trace_driver #(
    parameter int                ADDR_W  = 13,
    parameter int                DATA_W  = 32,
    parameter int                CNT_W   = 12,
    parameter int                STRIDE  = 1,
    parameter int                TIMEOUT = 255,
    parameter logic [DATA_W-1:0] WR_MASK = DATA_W'(32'hFFFF_FFFF)
) (
    input  logic              clk_in,
    input  logic              resetn_in,
    input  logic              start,
    input  logic [ADDR_W-1:0] end_addr,
    output logic [ADDR_W-1:0] trace_addr,
    input  logic [DATA_W-1:0] trace_data,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_wen,
    output logic [ADDR_W-1:0] req_addr,
    output logic [DATA_W-1:0] req_wdata,
    input  logic              rsp_valid,
    input  logic              rsp_hit,
    input  logic [DATA_W-1:0] rsp_rdata,
    output logic [CNT_W-1:0]  count,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count,
    output logic              rd_test_success,
    output logic              test_success,
    output logic              test_fail,
    output logic [1:0]        fail_code,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_expect,
    output logic [DATA_W-1:0] fail_got
);

    // The wait counter only has to reach TIMEOUT-1: the cycle it would hit TIMEOUT is the failing one.
    localparam int                TMO_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [ADDR_W:0]   STEP     = (ADDR_W + 1)'(STRIDE);

    typedef enum logic [3:0] {
        IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, VF_REQ, VF_WAIT, PASS, FAIL
    } state_t;

    state_t            state_q, state_d;
    state_t            same_req, next_phase;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  hit_q, hit_d;
    logic [CNT_W-1:0]  miss_q, miss_d;
    logic              rd_ok_q, rd_ok_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;
    logic [1:0]        code_q, code_d;
    logic [ADDR_W-1:0] faddr_q, faddr_d;
    logic [DATA_W-1:0] fexp_q, fexp_d;
    logic [DATA_W-1:0] fgot_q, fgot_d;

    // One extra bit on the sum catches wrap-around past the top of the address space.
    logic [ADDR_W:0]   next_sum;
    logic              last_acc;
    logic [DATA_W-1:0] wr_val;
    logic [DATA_W-1:0] exp_data;
    logic              data_bad;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (&v) ? v : v + CNT_W'(1);
    endfunction

    assign next_sum  = {1'b0, addr_q} + STEP;
    assign last_acc  = next_sum[ADDR_W] | (next_sum[ADDR_W-1:0] > end_addr);
    assign wr_val    = trace_data ^ WR_MASK;
    assign exp_data  = (state_q == RD_WAIT) ? trace_data : wr_val;
    assign data_bad  = ((state_q == RD_WAIT) || (state_q == VF_WAIT)) && (rsp_rdata != exp_data);

    assign trace_addr = addr_q;
    assign req_valid  = (state_q == RD_REQ) || (state_q == WR_REQ) || (state_q == VF_REQ);
    assign req_wen    = (state_q == WR_REQ);
    assign req_addr   = addr_q;
    assign req_wdata  = req_valid ? wr_val : '0;

    assign count           = count_q;
    assign hit_count       = hit_q;
    assign miss_count      = miss_q;
    assign rd_test_success = rd_ok_q;
    assign test_success    = pass_q;
    assign test_fail       = fail_q;
    assign fail_code       = code_q;
    assign fail_addr       = faddr_q;
    assign fail_expect     = fexp_q;
    assign fail_got        = fgot_q;

    // Per-phase lookup: where a wait state returns to for the next access, and where it goes when the range is done.
    always_comb begin
        same_req   = RD_REQ;
        next_phase = WR_REQ;
        case (state_q)
            WR_WAIT: begin
                same_req   = WR_REQ;
                next_phase = VF_REQ;
            end
            VF_WAIT: begin
                same_req   = VF_REQ;
                next_phase = PASS;
            end
            default: ;
        endcase
    end

    // Next-state logic: phase sequencing, response checking, timeout and sticky result capture.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        tmo_d   = tmo_q;
        count_d = count_q;
        hit_d   = hit_q;
        miss_d  = miss_q;
        rd_ok_d = rd_ok_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        code_d  = code_q;
        faddr_d = faddr_q;
        fexp_d  = fexp_q;
        fgot_d  = fgot_q;

        if ((state_q == RD_REQ) || (state_q == RD_WAIT)) begin
            count_d = sat_inc(count_q);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RD_REQ;
                    addr_d  = '0;
                    tmo_d   = '0;
                    count_d = '0;
                    hit_d   = '0;
                    miss_d  = '0;
                    rd_ok_d = 1'b0;
                    pass_d  = 1'b0;
                    fail_d  = 1'b0;
                    code_d  = 2'd0;
                    faddr_d = '0;
                    fexp_d  = '0;
                    fgot_d  = '0;
                end
            end
            RD_REQ: begin
                tmo_d = '0;
                if (req_ready) state_d = RD_WAIT;
            end
            WR_REQ: begin
                tmo_d = '0;
                if (req_ready) state_d = WR_WAIT;
            end
            VF_REQ: begin
                tmo_d = '0;
                if (req_ready) state_d = VF_WAIT;
            end
            RD_WAIT, WR_WAIT, VF_WAIT: begin
                if (rsp_valid) begin
                    if (rsp_hit) hit_d = sat_inc(hit_q);
                    else         miss_d = sat_inc(miss_q);
                    if (data_bad) begin
                        state_d = FAIL;
                        fail_d  = 1'b1;
                        code_d  = (state_q == RD_WAIT) ? 2'd1 : 2'd2;
                        faddr_d = addr_q;
                        fexp_d  = exp_data;
                        fgot_d  = rsp_rdata;
                    end else if (last_acc) begin
                        addr_d  = '0;
                        state_d = next_phase;
                        if (state_q == RD_WAIT)  rd_ok_d = 1'b1;
                        if (next_phase == PASS)  pass_d  = 1'b1;
                    end else begin
                        addr_d  = next_sum[ADDR_W-1:0];
                        state_d = same_req;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    // A response arriving in this same cycle takes the branch above instead.
                    state_d = FAIL;
                    fail_d  = 1'b1;
                    code_d  = 2'd3;
                    faddr_d = addr_q;
                    fexp_d  = exp_data;
                    fgot_d  = '0;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: ; // PASS and FAIL hold until reset
        endcase
    end

    // State and result registers; reset aborts any run, including a pending request.
    always_ff @(posedge clk_in or negedge resetn_in) begin
        if (!resetn_in) begin
            state_q <= IDLE;
            addr_q  <= '0;
            tmo_q   <= '0;
            count_q <= '0;
            hit_q   <= '0;
            miss_q  <= '0;
            rd_ok_q <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            code_q  <= 2'd0;
            faddr_q <= '0;
            fexp_q  <= '0;
            fgot_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            tmo_q   <= tmo_d;
            count_q <= count_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            rd_ok_q <= rd_ok_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            code_q  <= code_d;
            faddr_q <= faddr_d;
            fexp_q  <= fexp_d;
            fgot_q  <= fgot_d;
        end
    end

endmodule
